// File: rtl/common.sv
// Scalar type aliases shared across the core's pipe-level blocks.
package common;
  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/mips_mem_responder_pkg.sv
// Types for the instruction/data memory responder: FSM states, port select, request record.
package mips_mem_responder_pkg;
  import common::*;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  typedef enum logic       {PORT_I, PORT_D}   port_sel_t;

  typedef struct packed {
    u32    addr;
    u1     we;
    word_t wdata;
  } mem_req_t;

  localparam int unsigned CNT_W = 4;

  function automatic u1 is_misaligned(input u32 addr);
    return addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/mips_mem_responder_if.sv
// Instruction and data request/response channels between the core and the memory responder.
interface mips_mem_responder_if;
  import common::*;

  u1     ireq_valid;
  u32    ireq_addr;
  u1     ireq_ready;
  u1     iresp_valid;
  word_t iresp_data;
  u1     dreq_valid;
  u32    dreq_addr;
  u1     dreq_we;
  word_t dreq_wdata;
  u1     dreq_ready;
  u1     dresp_valid;
  word_t dresp_rdata;
  u1     err_misalign;

  modport master (
    output ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_we, dreq_wdata,
    input  ireq_ready, iresp_valid, iresp_data, dreq_ready, dresp_valid, dresp_rdata,
           err_misalign
  );

  modport slave (
    input  ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_we, dreq_wdata,
    output ireq_ready, iresp_valid, iresp_data, dreq_ready, dresp_valid, dresp_rdata,
           err_misalign
  );
endinterface

// File: rtl/mips_mem_responder_mem_array.sv
// Word array with one synchronous write port and one combinational read port; contents never reset.
module mips_mem_responder_mem_array
  import common::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  word_t            wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output word_t            rdata_o
);
  word_t mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mips_mem_responder.sv
// Shared-array memory responder: round-robin I/D arbitration, one outstanding request,
// WAIT_CYCLES wait states, one-cycle registered response pulse.
module mips_mem_responder
  import common::*;
  import mips_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 reset,
  mips_mem_responder_if.slave bus
);
  localparam int unsigned     IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  port_sel_t        rr_last_q, rr_last_d;
  port_sel_t        port_q, port_d;
  mem_req_t         req_q, req_d;
  u1                iresp_valid_q, iresp_valid_d, dresp_valid_q, dresp_valid_d;
  u1                err_q, err_d;
  word_t            irdata_q, irdata_d, drdata_q, drdata_d;

  u1                grant_i, grant_d, accept, enter_resp, cur_mis, mem_we;
  port_sel_t        cur_port;
  mem_req_t         cur_req;
  logic [IDX_W-1:0] cur_idx;
  word_t            mem_rdata;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE && reset) begin
      grant_d = bus.dreq_valid && (!bus.ireq_valid || rr_last_q == PORT_I);
      grant_i = bus.ireq_valid && (!bus.dreq_valid || rr_last_q == PORT_D);
    end
  end

  assign accept         = grant_i | grant_d;
  assign bus.ireq_ready = grant_i;
  assign bus.dreq_ready = grant_d;

  // In IDLE the incoming request is used directly, so WAIT_CYCLES=0 writes/reads on the accept edge.
  always_comb begin
    cur_port = port_q;
    cur_req  = req_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        cur_port      = PORT_D;
        cur_req.addr  = bus.dreq_addr;
        cur_req.we    = bus.dreq_we;
        cur_req.wdata = bus.dreq_wdata;
      end else begin
        cur_port      = PORT_I;
        cur_req.addr  = bus.ireq_addr;
        cur_req.we    = 1'b0;
        cur_req.wdata = '0;
      end
    end
  end

  assign cur_idx = cur_req.addr[2 +: IDX_W];
  assign cur_mis = is_misaligned(cur_req.addr);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_last_d  = rr_last_q;
    port_d     = port_q;
    req_d      = req_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          port_d    = cur_port;
          req_d     = cur_req;
          rr_last_d = cur_port;
          cnt_d     = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    iresp_valid_d = enter_resp && cur_port == PORT_I;
    dresp_valid_d = enter_resp && cur_port == PORT_D;
    err_d         = enter_resp && cur_mis;
    irdata_d      = (iresp_valid_d && !cur_mis) ? mem_rdata : '0;
    drdata_d      = (dresp_valid_d && !cur_mis && !cur_req.we) ? mem_rdata : '0;
  end

  assign mem_we = enter_resp && cur_req.we && !cur_mis && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rr_last_q     <= PORT_I;
      port_q        <= PORT_I;
      req_q         <= '0;
      iresp_valid_q <= 1'b0;
      dresp_valid_q <= 1'b0;
      err_q         <= 1'b0;
      irdata_q      <= '0;
      drdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_last_q     <= rr_last_d;
      port_q        <= port_d;
      req_q         <= req_d;
      iresp_valid_q <= iresp_valid_d;
      dresp_valid_q <= dresp_valid_d;
      err_q         <= err_d;
      irdata_q      <= irdata_d;
      drdata_q      <= drdata_d;
    end
  end

  assign bus.iresp_valid  = iresp_valid_q;
  assign bus.iresp_data   = irdata_q;
  assign bus.dresp_valid  = dresp_valid_q;
  assign bus.dresp_rdata  = drdata_q;
  assign bus.err_misalign = err_q;

  mips_mem_responder_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (cur_idx),
    .wdata_i (cur_req.wdata),
    .raddr_i (cur_idx),
    .rdata_o (mem_rdata)
  );
endmodule
